hbm_axi_responder: RTL and testbench

- AXI4 memory-mapped slave (responder) answering one CGRA data-path HBM column master port (the mNN_axi_* read/write channels).
- Backs the column with an on-chip PHIT-wide RAM so data-path load/store instructions run without real HBM.
- Used in block-level benches and in the HBM-less bring-up build; one instance per column.
- Read and write channels are fully independent, each with its own FSM.

---
 rtl/cgra_axi_pkg.sv | 21 ++
 rtl/hbm_resp_ram.sv | 39 +++
 rtl/hbm_axi_responder.sv | 201 ++++++++++++++++++++
 tb/tb_hbm_axi_responder.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgra_axi_pkg.sv
// Shared AXI definitions for the CGRA HBM column responder.
//   RESP_OKAY / RESP_SLVERR : AXI response codes
//   rd_state_t              : read channel FSM states
//   wr_state_t              : write channel FSM states
package cgra_axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_t;

endpackage

// File: rtl/hbm_resp_ram.sv
// Simple dual-port byte-enabled RAM backing one HBM column.
//   clk, rst_n      : clock, async active-low reset (read register only)
//   rd_en, rd_addr  : read request, data appears in rd_data after the edge
//   rd_data         : registered read data, read-before-write on collision
//   wr_en, wr_addr  : write request
//   wr_data, wr_strb: write data and per-byte enables
module hbm_resp_ram #(
    parameter int DW    = 512,
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [DW-1:0]   rd_data,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    input  logic [DW/8-1:0] wr_strb
);

    logic [DW-1:0] mem [DEPTH];

    // Contents survive reset; only the output register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < DW/8; i++) begin
                if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/hbm_axi_responder.sv
// AXI4 slave backing one CGRA data-path HBM column with on-chip RAM.
//   ap_clk, ap_rst_n : kernel clock, async active-low reset
//   s_axi_ar*/r*     : read address / read data channels (INCR bursts)
//   s_axi_aw*/w*/b*  : write address / data / response channels
//   err_count        : saturating count of SLVERR responses issued
//
// state   | meaning
// R_IDLE  | waiting for AR handshake, arready high
// R_BURST | streaming read beats, rdata holds until rready
// W_IDLE  | waiting for AW handshake, awready high
// W_DATA  | accepting write beats until wlast
// W_RESP  | presenting write response until bready
module hbm_axi_responder
    import cgra_axi_pkg::*;
#(
    parameter  int PHIT_SIZE  = 512,
    parameter  int ADDR_WIDTH = 64,
    parameter  int DEPTH      = 1024,
    localparam int WORD_LSB   = $clog2(PHIT_SIZE/8),
    localparam int IDX_W      = $clog2(DEPTH)
) (
    input  logic                   ap_clk,
    input  logic                   ap_rst_n,
    input  logic [ADDR_WIDTH-1:0]  s_axi_araddr,
    input  logic [7:0]             s_axi_arlen,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    output logic [PHIT_SIZE-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   s_axi_rlast,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr,
    input  logic [7:0]             s_axi_awlen,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [PHIT_SIZE-1:0]   s_axi_wdata,
    input  logic [PHIT_SIZE/8-1:0] s_axi_wstrb,
    input  logic                   s_axi_wlast,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    output logic [1:0]             s_axi_bresp,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic [15:0]            err_count
);

    rd_state_t        rd_state, rd_state_nxt;
    logic [IDX_W-1:0] rptr, rptr_nxt;
    logic [7:0]       rcnt, rcnt_nxt;
    logic             ram_rd_en;
    logic [IDX_W-1:0] ram_rd_addr;

    wr_state_t        wr_state, wr_state_nxt;
    logic [IDX_W-1:0] wptr, wptr_nxt;
    logic [7:0]       wcnt, wcnt_nxt;
    logic             werr, werr_nxt, len_err;
    logic [1:0]       bresp_q, bresp_nxt;
    logic [15:0]      err_cnt_q, err_cnt_nxt;
    logic             ram_we;

    logic [IDX_W-1:0] ar_idx, aw_idx;
    logic             unused_addr_bits;

    // Upper address bits and the byte offset do not select a word.
    assign ar_idx = s_axi_araddr[WORD_LSB +: IDX_W];
    assign aw_idx = s_axi_awaddr[WORD_LSB +: IDX_W];
    assign unused_addr_bits = ^{s_axi_araddr[ADDR_WIDTH-1:WORD_LSB+IDX_W], s_axi_araddr[WORD_LSB-1:0],
                                s_axi_awaddr[ADDR_WIDTH-1:WORD_LSB+IDX_W], s_axi_awaddr[WORD_LSB-1:0]};

    // rptr always points at the word to fetch for the *next* beat, so the
    // RAM register can reload on the same edge that retires a beat.
    always_comb begin
        rd_state_nxt  = rd_state;
        rptr_nxt      = rptr;
        rcnt_nxt      = rcnt;
        ram_rd_en     = 1'b0;
        ram_rd_addr   = rptr;
        s_axi_arready = 1'b0;
        s_axi_rvalid  = 1'b0;
        case (rd_state)
            R_IDLE: begin
                s_axi_arready = 1'b1;
                if (s_axi_arvalid) begin
                    ram_rd_en    = 1'b1;
                    ram_rd_addr  = ar_idx;
                    rptr_nxt     = ar_idx + 1'b1;
                    rcnt_nxt     = s_axi_arlen;
                    rd_state_nxt = R_BURST;
                end
            end
            R_BURST: begin
                s_axi_rvalid = 1'b1;
                if (s_axi_rready) begin
                    if (rcnt == 8'd0) begin
                        rd_state_nxt = R_IDLE;
                    end else begin
                        ram_rd_en = 1'b1;
                        rptr_nxt  = rptr + 1'b1;
                        rcnt_nxt  = rcnt - 8'd1;
                    end
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    assign s_axi_rlast = (rd_state == R_BURST) && (rcnt == 8'd0);
    assign s_axi_rresp = RESP_OKAY;

    // A beat is mis-framed when wlast disagrees with the remaining count;
    // wcnt parks at zero so overlong bursts keep flagging.
    assign len_err = werr | (s_axi_wlast != (wcnt == 8'd0));

    always_comb begin
        wr_state_nxt  = wr_state;
        wptr_nxt      = wptr;
        wcnt_nxt      = wcnt;
        werr_nxt      = werr;
        bresp_nxt     = bresp_q;
        err_cnt_nxt   = err_cnt_q;
        ram_we        = 1'b0;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            W_IDLE: begin
                s_axi_awready = 1'b1;
                if (s_axi_awvalid) begin
                    wptr_nxt     = aw_idx;
                    wcnt_nxt     = s_axi_awlen;
                    werr_nxt     = 1'b0;
                    wr_state_nxt = W_DATA;
                end
            end
            W_DATA: begin
                s_axi_wready = 1'b1;
                if (s_axi_wvalid) begin
                    ram_we   = 1'b1;
                    wptr_nxt = wptr + 1'b1;
                    werr_nxt = len_err;
                    if (wcnt != 8'd0) wcnt_nxt = wcnt - 8'd1;
                    if (s_axi_wlast) begin
                        wr_state_nxt = W_RESP;
                        bresp_nxt    = len_err ? RESP_SLVERR : RESP_OKAY;
                        if (len_err && err_cnt_q != 16'hFFFF) err_cnt_nxt = err_cnt_q + 16'd1;
                    end
                end
            end
            W_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready) wr_state_nxt = W_IDLE;
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rd_state  <= R_IDLE;
            rptr      <= '0;
            rcnt      <= '0;
            wr_state  <= W_IDLE;
            wptr      <= '0;
            wcnt      <= '0;
            werr      <= 1'b0;
            bresp_q   <= RESP_OKAY;
            err_cnt_q <= '0;
        end else begin
            rd_state  <= rd_state_nxt;
            rptr      <= rptr_nxt;
            rcnt      <= rcnt_nxt;
            wr_state  <= wr_state_nxt;
            wptr      <= wptr_nxt;
            wcnt      <= wcnt_nxt;
            werr      <= werr_nxt;
            bresp_q   <= bresp_nxt;
            err_cnt_q <= err_cnt_nxt;
        end
    end

    assign s_axi_bresp = bresp_q;
    assign err_count   = err_cnt_q;

    hbm_resp_ram #(
        .DW    (PHIT_SIZE),
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .rd_en   (ram_rd_en),
        .rd_addr (ram_rd_addr),
        .rd_data (s_axi_rdata),
        .wr_en   (ram_we),
        .wr_addr (wptr),
        .wr_data (s_axi_wdata),
        .wr_strb (s_axi_wstrb)
    );

endmodule

// File: tb/tb_hbm_axi_responder.sv
module tb_hbm_axi_responder;

    localparam int DW  = 512;
    localparam int DEP = 1024;

    logic           ap_clk = 1'b0;
    logic           ap_rst_n = 1'b0;
    logic [63:0]    s_axi_araddr = '0;
    logic [7:0]     s_axi_arlen = '0;
    logic           s_axi_arvalid = 1'b0;
    logic           s_axi_arready;
    logic [DW-1:0]  s_axi_rdata;
    logic [1:0]     s_axi_rresp;
    logic           s_axi_rlast;
    logic           s_axi_rvalid;
    logic           s_axi_rready = 1'b0;
    logic [63:0]    s_axi_awaddr = '0;
    logic [7:0]     s_axi_awlen = '0;
    logic           s_axi_awvalid = 1'b0;
    logic           s_axi_awready;
    logic [DW-1:0]  s_axi_wdata = '0;
    logic [DW/8-1:0] s_axi_wstrb = '0;
    logic           s_axi_wlast = 1'b0;
    logic           s_axi_wvalid = 1'b0;
    logic           s_axi_wready;
    logic [1:0]     s_axi_bresp;
    logic           s_axi_bvalid;
    logic           s_axi_bready = 1'b0;
    logic [15:0]    err_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_err  = 0;

    // Reference memory: word contents plus a flag for words whose every byte
    // the bench has defined.
    logic [DW-1:0] mm [DEP];
    bit            known [DEP];

    hbm_axi_responder dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .err_count     (err_count)
    );

    always #5 ap_clk = ~ap_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] rand_phit();
        logic [DW-1:0] v;
        for (int i = 0; i < DW/32; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Random upper bits and byte offset: only the word index may matter.
    function automatic logic [63:0] mk_addr(input int idx);
        logic [63:0] a;
        a = {$urandom, $urandom};
        a[15:6] = idx[9:0];
        return a;
    endfunction

    task automatic pulse_reset();
        ap_rst_n      = 1'b0;
        s_axi_arvalid = 1'b0;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_wlast   = 1'b0;
        s_axi_rready  = 1'b0;
        s_axi_bready  = 1'b0;
        #1;
        chk("rst_rvalid",  s_axi_rvalid,  0);
        chk("rst_rlast",   s_axi_rlast,   0);
        chk("rst_wready",  s_axi_wready,  0);
        chk("rst_bvalid",  s_axi_bvalid,  0);
        chk("rst_bresp",   s_axi_bresp,   0);
        chk("rst_arready", s_axi_arready, 1);
        chk("rst_awready", s_axi_awready, 1);
        chk("rst_rdata",   s_axi_rdata,   0);
        chk("rst_errcnt",  err_count,     0);
        exp_err = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);
        chk("post_rst_arready", s_axi_arready, 1);
        chk("post_rst_awready", s_axi_awready, 1);
    endtask

    // strb_mode: 0 full/random data, 1 low 4 bytes/zero data,
    //            2 random strobe/random data, 3 full/all-ones data
    task automatic do_write(input int idx, input int len, input int nbeats,
                            input int strb_mode, input int abort_after);
        logic [DW-1:0]   d;
        logic [DW/8-1:0] s;
        logic [1:0]      exp_resp;
        int t, w;
        @(negedge ap_clk);
        s_axi_awaddr  = mk_addr(idx);
        s_axi_awlen   = len[7:0];
        s_axi_awvalid = 1'b1;
        t = 0;
        while (!s_axi_awready && t < 100) begin @(negedge ap_clk); t++; end
        if (t >= 100) chk("aw_timeout", 0, 1);
        @(negedge ap_clk);
        s_axi_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            if (b == abort_after) begin
                pulse_reset();
                return;
            end
            if ($urandom_range(0, 3) == 0) begin
                s_axi_wvalid = 1'b0;
                @(negedge ap_clk);
            end
            case (strb_mode)
                1:       begin d = '0;         s = 64'h0000_0000_0000_000F; end
                2:       begin d = rand_phit(); s = {$urandom, $urandom}; end
                3:       begin d = '1;         s = '1; end
                default: begin d = rand_phit(); s = '1; end
            endcase
            s_axi_wdata  = d;
            s_axi_wstrb  = s;
            s_axi_wlast  = (b == nbeats - 1);
            s_axi_wvalid = 1'b1;
            t = 0;
            while (!s_axi_wready && t < 100) begin @(negedge ap_clk); t++; end
            if (t >= 100) chk("w_timeout", 0, 1);
            @(negedge ap_clk);
            w = (idx + b) % DEP;
            for (int j = 0; j < DW/8; j++) if (s[j]) mm[w][8*j +: 8] = d[8*j +: 8];
            if (&s) known[w] = 1'b1;
        end
        s_axi_wvalid = 1'b0;
        s_axi_wlast  = 1'b0;
        t = 0;
        while (!s_axi_bvalid && t < 100) begin @(negedge ap_clk); t++; end
        if (t >= 100) chk("b_timeout", 0, 1);
        exp_resp = (nbeats == len + 1) ? 2'b00 : 2'b10;
        if (exp_resp == 2'b10 && exp_err < 16'hFFFF) exp_err++;
        t = $urandom_range(0, 2);
        repeat (t) begin
            chk("bvalid_hold", s_axi_bvalid, 1);
            @(negedge ap_clk);
        end
        chk("bresp", s_axi_bresp, exp_resp);
        chk("err_count", err_count, exp_err);
        s_axi_bready = 1'b1;
        @(negedge ap_clk);
        s_axi_bready = 1'b0;
        chk("bvalid_once", s_axi_bvalid, 0);
        chk("awready_ret", s_axi_awready, 1);
    endtask

    // rmode: 0 rready always, 1 pattern 1,0,0,..., 2 random
    task automatic do_read(input int idx, input int len, input int rmode, input int abort_after);
        int t, beat, cyc, i;
        logic rdy;
        @(negedge ap_clk);
        chk("rvalid_idle", s_axi_rvalid, 0);
        s_axi_araddr  = mk_addr(idx);
        s_axi_arlen   = len[7:0];
        s_axi_arvalid = 1'b1;
        t = 0;
        while (!s_axi_arready && t < 100) begin @(negedge ap_clk); t++; end
        if (t >= 100) chk("ar_timeout", 0, 1);
        @(negedge ap_clk);
        s_axi_arvalid = 1'b0;
        chk("rvalid_latency", s_axi_rvalid, 1);
        chk("arready_busy", s_axi_arready, 0);
        beat = 0;
        cyc  = 0;
        while (beat <= len && cyc < 500) begin
            if (beat == abort_after) begin
                pulse_reset();
                return;
            end
            i = (idx + beat) % DEP;
            chk("rvalid", s_axi_rvalid, 1);
            chk("rresp", s_axi_rresp, 0);
            if (known[i]) chk("rdata", s_axi_rdata, mm[i]);
            chk("rlast", s_axi_rlast, beat == len);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 3 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            s_axi_rready = rdy;
            @(negedge ap_clk);
            cyc++;
            if (rdy) beat++;
        end
        s_axi_rready = 1'b0;
        if (cyc >= 500) chk("r_timeout", 0, 1);
        chk("rvalid_done", s_axi_rvalid, 0);
        chk("arready_done", s_axi_arready, 1);
    endtask

    initial begin
        int idx, len, nb;
        for (int k = 0; k < DEP; k++) begin
            mm[k]    = '0;
            known[k] = 1'b0;
        end
        repeat (3) @(negedge ap_clk);
        chk("reset_arready", s_axi_arready, 1);
        chk("reset_awready", s_axi_awready, 1);
        chk("reset_rvalid",  s_axi_rvalid,  0);
        chk("reset_rlast",   s_axi_rlast,   0);
        chk("reset_wready",  s_axi_wready,  0);
        chk("reset_bvalid",  s_axi_bvalid,  0);
        chk("reset_bresp",   s_axi_bresp,   0);
        chk("reset_rdata",   s_axi_rdata,   0);
        chk("reset_errcnt",  err_count,     0);
        ap_rst_n = 1'b1;
        @(negedge ap_clk);

        // 4-beat burst at byte 0x40, read back
        do_write(1, 3, 4, 0, -1);
        do_read(1, 3, 0, -1);

        // 8 beats with rready stalls
        do_write(16, 7, 8, 0, -1);
        do_read(16, 7, 1, -1);

        // partial strobe over all-ones word
        do_write(40, 0, 1, 3, -1);
        do_write(40, 0, 1, 1, -1);
        do_read(40, 0, 0, -1);

        // length errors: early wlast, then late wlast
        do_write(60, 1, 1, 0, -1);
        do_write(62, 1, 3, 0, -1);

        // wrap at the top of the RAM
        do_write(DEP - 2, 3, 4, 0, -1);
        do_read(DEP - 2, 3, 0, -1);
        do_read(0, 1, 2, -1);

        // random bursts, some mis-framed, with a concurrent independent read
        for (int r = 0; r < 12; r++) begin
            idx = $urandom_range(200, 900);
            len = $urandom_range(0, 7);
            nb  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 9) : len + 1;
            fork
                do_write(idx, len, nb, ($urandom_range(0, 2) == 0) ? 2 : 0, -1);
                do_read(16, 7, 2, -1);
            join
            do_read(idx, nb - 1, 2, -1);
        end

        // reset in the middle of a read burst (beat 2 of 8)
        do_read(16, 7, 0, 2);
        do_read(16, 7, 0, -1);

        // reset in the middle of a write burst; two beats already committed
        do_write(100, 3, 4, 0, -1);
        do_write(100, 3, 4, 0, 2);
        do_read(100, 3, 0, -1);
        do_write(60, 1, 1, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
